seg_display_mux: RTL and testbench

- Parametrised N-digit multiplexed seven-segment display controller; successor to the fixed 2-digit toggling display driver.
- Sits on the SoC IO bus: the CPU writes value, decimal-point, blank and control registers.
- Scans digits at a programmable rate, applies PWM brightness, leading-zero suppression and per-digit blanking.
- Register updates are double-buffered and applied only at frame boundaries, so the display never shows a torn value.

---
 rtl/seg_display_mux.sv | 172 +++++++++++++++++
 tb/tb_seg_display_mux.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_mux.sv
// Multiplexed N-digit seven-segment display controller.
// Double-buffered registers, PWM brightness, leading-zero suppression.
module seg_display_mux #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 12,
    parameter int BRIGHT_RESET = 15
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              WE,
    input  logic [1:0]        WADDR,
    input  logic [31:0]       WDATA,
    output logic [6:0]        seg_pins_n,
    output logic              dp_n,
    output logic [DIGITS-1:0] digit_sel_n,
    output logic              frame_tick,
    output logic              update_pending
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW = 4 * DIGITS;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
    localparam logic [3:0] BR_RST = 4'(BRIGHT_RESET);

    logic [SCAN_DIV-1:0] presc;
    logic [IW-1:0]       idx;
    logic                slot_tick;
    logic                wrap;

    logic [VW-1:0]     sh_value, act_value;
    logic [DIGITS-1:0] sh_dp, act_dp;
    logic [DIGITS-1:0] sh_blank, act_blank;
    logic              sh_en, act_en;
    logic [3:0]        sh_bright, act_bright;
    logic              sh_lzs, act_lzs;

    logic [3:0]        nib;
    logic [DIGITS-1:0] upper_zero;
    logic [DIGITS-1:0] sel_onehot;
    logic              suppressed;
    logic              lit;

    // Upper WDATA bits beyond the widest field carry no meaning.
    logic unused_wdata;
    assign unused_wdata = ^WDATA;

    assign slot_tick = &presc;
    assign wrap      = slot_tick && (idx == LAST);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Free-running prescaler and digit scan index.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= presc + 1'b1;
            if (wrap) begin
                idx <= '0;
            end else if (slot_tick) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // CPU-visible shadow registers take writes on any cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sh_value  <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            sh_en     <= 1'b1;
            sh_bright <= BR_RST;
            sh_lzs    <= 1'b0;
        end else if (WE) begin
            case (WADDR)
                2'd0: sh_value <= WDATA[VW-1:0];
                2'd1: sh_dp    <= WDATA[DIGITS-1:0];
                2'd2: sh_blank <= WDATA[DIGITS-1:0];
                default: begin
                    sh_en     <= WDATA[0];
                    sh_bright <= WDATA[4:1];
                    sh_lzs    <= WDATA[5];
                end
            endcase
        end
    end

    // Active set copies shadow only at the frame wrap, so frames never tear.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            act_value      <= '0;
            act_dp         <= '0;
            act_blank      <= '0;
            act_en         <= 1'b1;
            act_bright     <= BR_RST;
            act_lzs        <= 1'b0;
            frame_tick     <= 1'b0;
            update_pending <= 1'b0;
        end else begin
            frame_tick <= wrap;
            if (wrap) begin
                act_value  <= sh_value;
                act_dp     <= sh_dp;
                act_blank  <= sh_blank;
                act_en     <= sh_en;
                act_bright <= sh_bright;
                act_lzs    <= sh_lzs;
            end
            if (WE) begin
                update_pending <= 1'b1;
            end else if (wrap) begin
                update_pending <= 1'b0;
            end
        end
    end

    // Decide whether the current digit is lit and what it shows.
    always_comb begin
        nib = act_value[4*idx +: 4];
        upper_zero = '0;
        upper_zero[DIGITS-1] = (act_value[VW-1 -: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (act_value[4*i +: 4] == 4'h0);
        end
        suppressed = act_lzs && (idx != '0) && upper_zero[idx];
        lit = act_en && !act_blank[idx]
            && (presc[SCAN_DIV-1 -: 4] <= act_bright)
            && (!suppressed || act_dp[idx]);
        sel_onehot = DIGITS'(1) << idx;
    end

    // Registered pin drivers; everything dark when the digit is unlit.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            seg_pins_n  <= 7'h7F;
            dp_n        <= 1'b1;
            digit_sel_n <= '1;
        end else if (lit) begin
            seg_pins_n  <= suppressed ? 7'h7F : ~hex7(nib);
            dp_n        <= ~act_dp[idx];
            digit_sel_n <= ~sel_onehot;
        end else begin
            seg_pins_n  <= 7'h7F;
            dp_n        <= 1'b1;
            digit_sel_n <= '1;
        end
    end

endmodule

// File: tb/tb_seg_display_mux.sv
// Bench for seg_display_mux: cycle model feeds a scoreboard queue,
// plus directed checks on frame period, duty and async reset.
module tb_seg_display_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  waddr = 2'd0;
    logic [31:0] wdata = 32'd0;
    logic [6:0]  seg_pins_n;
    logic        dp_n;
    logic [3:0]  digit_sel_n;
    logic        frame_tick;
    logic        update_pending;

    int checks = 0;
    int errors = 0;

    seg_display_mux #(
        .DIGITS(4),
        .SCAN_DIV(4),
        .BRIGHT_RESET(15)
    ) dut (
        .CLK(clk),
        .RESET_N(rst_n),
        .WE(we),
        .WADDR(waddr),
        .WDATA(wdata),
        .seg_pins_n(seg_pins_n),
        .dp_n(dp_n),
        .digit_sel_n(digit_sel_n),
        .frame_tick(frame_tick),
        .update_pending(update_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] sel;
        logic       ft;
        logic       up;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic [3:0]  m_presc;
    logic [1:0]  m_idx;
    logic        m_pend;
    logic [15:0] s_val, a_val;
    logic [3:0]  s_dp, a_dp, s_blank, a_blank, s_br, a_br;
    logic        s_en, a_en, s_lzs, a_lzs;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge rst_n) exp_q.delete();

    // Reference model: predicts the pins that appear after each edge.
    always @(posedge clk) begin : model
        exp_t e;
        logic [3:0] nib;
        logic sup, lit, wrap;
        if (!rst_n) begin
            m_presc = 0; m_idx = 0; m_pend = 0;
            s_val = 0; s_dp = 0; s_blank = 0;
            s_en = 1; s_br = 4'd15; s_lzs = 0;
            a_val = 0; a_dp = 0; a_blank = 0;
            a_en = 1; a_br = 4'd15; a_lzs = 0;
            e = '{seg: 7'h7F, dp: 1'b1, sel: 4'hF, ft: 1'b0, up: 1'b0};
        end else begin
            nib = a_val[m_idx*4 +: 4];
            sup = a_lzs && (m_idx != 0) && ((a_val >> (m_idx*4)) == 16'h0);
            lit = a_en && !a_blank[m_idx] && (m_presc <= a_br)
                && (!sup || a_dp[m_idx]);
            e.sel = lit ? ~(4'b0001 << m_idx) : 4'hF;
            e.seg = lit ? (sup ? 7'h7F : ~HEX[nib]) : 7'h7F;
            e.dp  = lit ? ~a_dp[m_idx] : 1'b1;
            wrap  = (m_presc == 4'd15) && (m_idx == 2'd3);
            e.ft  = wrap;
            if (wrap) begin
                a_val = s_val; a_dp = s_dp; a_blank = s_blank;
                a_en = s_en; a_br = s_br; a_lzs = s_lzs;
            end
            if (we) begin
                case (waddr)
                    2'd0: s_val = wdata[15:0];
                    2'd1: s_dp = wdata[3:0];
                    2'd2: s_blank = wdata[3:0];
                    default: begin
                        s_en = wdata[0]; s_br = wdata[4:1]; s_lzs = wdata[5];
                    end
                endcase
                m_pend = 1'b1;
            end else if (wrap) begin
                m_pend = 1'b0;
            end
            e.up = m_pend;
            if (m_presc == 4'd15) m_idx = wrap ? 2'd0 : m_idx + 2'd1;
            m_presc = m_presc + 4'd1;
        end
        exp_q.push_back(e);
    end

    // Scoreboard: compare one predicted entry per cycle.
    always @(negedge clk) begin : scoreboard
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("seg", 32'(seg_pins_n), 32'(e.seg));
            chk("dp", 32'(dp_n), 32'(e.dp));
            chk("sel", 32'(digit_sel_n), 32'(e.sel));
            chk("frame_tick", 32'(frame_tick), 32'(e.ft));
            chk("pending", 32'(update_pending), 32'(e.up));
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 200);
        chk("frame_timeout", 32'(frame_tick), 32'd1);
    endtask

    task automatic count_lit(input string tag, input int expv);
        int lit = 0;
        repeat (64) begin
            @(negedge clk);
            if (digit_sel_n !== 4'hF) lit++;
        end
        chk(tag, 32'(lit), 32'(expv));
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Frame period after reset.
        wait_frame();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 200);
        chk("frame_period", 32'(n), 32'd64);

        // Mid-frame value update.
        repeat (20) @(negedge clk);
        wr(2'd0, 32'h0000_12AF);
        wait_frame();
        repeat (64) @(negedge clk);

        // Leading-zero suppression with dp on a suppressed digit.
        wr(2'd0, 32'h0000_0050);
        wr(2'd1, 32'h0000_0008);
        wr(2'd3, 32'h0000_003F);
        wait_frame();
        repeat (64) @(negedge clk);

        // Brightness and enable.
        wr(2'd3, 32'h0000_0007);
        wait_frame();
        count_lit("lit_bright3", 16);
        wr(2'd3, 32'h0000_0001);
        wait_frame();
        count_lit("lit_bright0", 4);
        wr(2'd3, 32'h0000_001E);
        wait_frame();
        count_lit("lit_disabled", 0);
        wr(2'd3, 32'h0000_001F);
        wait_frame();

        // Write landing exactly on the wrap edge.
        repeat (63) @(negedge clk);
        we = 1'b1; waddr = 2'd0; wdata = 32'h0000_1234;
        @(negedge clk);
        we = 1'b0;
        chk("wrap_write_tick", 32'(frame_tick), 32'd1);
        chk("wrap_write_pend", 32'(update_pending), 32'd1);
        repeat (128) @(negedge clk);

        // Per-digit blanking.
        wr(2'd2, 32'h0000_0002);
        wait_frame();
        repeat (64) @(negedge clk);

        // Async reset mid-frame with a write pending.
        wait_frame();
        wr(2'd0, 32'h0000_9999);
        repeat (35) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_seg", 32'(seg_pins_n), 32'h7F);
        chk("rst_dp", 32'(dp_n), 32'd1);
        chk("rst_sel", 32'(digit_sel_n), 32'hF);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        chk("rst_pend", 32'(update_pending), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_frame();
        repeat (64) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
